// File: rtl/router_pkg.sv
// router_pkg: router header layout, output FIFO timeout and reader FSM states
package router_pkg;
    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = 2;
    localparam int LEN_W = LEN_MSB - LEN_LSB + 1;
    localparam int ADDR_W = 2;
    localparam int FIFO_TIMEOUT = 30;
    typedef enum logic [1:0] {IDLE, WAIT, READ, DRAIN} state_t;
endpackage

// File: rtl/router_rx_parity.sv
// router_rx_parity: running XOR over header and payload, compared against the trailing parity byte
module router_rx_parity #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              clr,
    input  logic              seed,
    input  logic              acc,
    input  logic [DATA_W-1:0] din,
    output logic              mismatch
);
    logic [DATA_W-1:0] sum;

    always_ff @(posedge clock) begin
        if (!resetn || clr) sum <= '0;
        else if (seed) sum <= din;
        else if (acc) sum <= sum ^ din;
    end

    assign mismatch = sum != din;
endmodule

// File: rtl/router_out_reader.sv
// router_out_reader: drains one router output port ahead of its FIFO timeout and checks each packet
// ROUTER_RX_STATS_EN adds saturating good/error packet counters
module router_out_reader
    import router_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PORT_ID = 0,
    parameter int READ_DLY = 0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              vld_out,
    input  logic [DATA_W-1:0] data_out,
    input  logic              soft_reset,
    output logic              read_enb,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_sop,
    output logic              rx_eop,
    output logic              pkt_done,
    output logic              parity_err,
    output logic              addr_err,
    output logic              abort,
    output logic              busy
`ifdef ROUTER_RX_STATS_EN
    ,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       err_cnt
`endif
);
    localparam logic [ADDR_W-1:0] MY_ADDR = ADDR_W'(PORT_ID);

    state_t           state;
    logic [4:0]       dly;
    logic [LEN_W-1:0] len;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W:0]   issued, rx_idx, total;
    logic             hdr_known, rd_q, mismatch, kill, is_hdr, is_par, done;

    if (READ_DLY > FIFO_TIMEOUT - 2) begin : g_dly_chk
        $fatal(1, "router_out_reader: READ_DLY exceeds FIFO_TIMEOUT-2");
    end

    // Until the header returns the length is unknown; at most two reads can be in flight by then.
    assign total    = {1'b0, len} + (LEN_W + 1)'(2);
    assign kill     = soft_reset && state != IDLE;
    assign read_enb = state == READ && vld_out && (!hdr_known || issued < total) && !kill;
    assign is_hdr   = rd_q && !hdr_known;
    assign is_par   = rd_q && hdr_known && rx_idx == {1'b0, len} + (LEN_W + 1)'(1);
    assign done     = is_par && !kill;
    assign busy     = state != IDLE;

    router_rx_parity #(.DATA_W(DATA_W)) u_parity (
        .clock   (clock),
        .resetn  (resetn),
        .clr     (kill || done),
        .seed    (is_hdr),
        .acc     (rd_q && hdr_known && !is_par),
        .din     (data_out),
        .mismatch(mismatch)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            dly        <= '0;
            len        <= '0;
            addr       <= '0;
            hdr_known  <= 1'b0;
            rd_q       <= 1'b0;
            issued     <= '0;
            rx_idx     <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_sop     <= 1'b0;
            rx_eop     <= 1'b0;
            pkt_done   <= 1'b0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
            abort      <= 1'b0;
        end else begin
            rd_q       <= read_enb;
            rx_valid   <= rd_q && !kill;
            rx_sop     <= is_hdr && !kill;
            rx_eop     <= done;
            pkt_done   <= done;
            parity_err <= done && mismatch;
            addr_err   <= done && addr != MY_ADDR;
            abort      <= kill;
            if (rd_q) rx_data <= data_out;
            if (rd_q) rx_idx <= rx_idx + 1'b1;
            if (read_enb) issued <= issued + 1'b1;
            if (is_hdr) begin
                len       <= data_out[LEN_MSB:LEN_LSB];
                addr      <= data_out[ADDR_W-1:0];
                hdr_known <= 1'b1;
            end
            if (kill || done) begin
                state     <= IDLE;
                hdr_known <= 1'b0;
                issued    <= '0;
                rx_idx    <= '0;
            end else begin
                case (state)
                    IDLE: if (vld_out) begin
                        state <= READ_DLY == 0 ? READ : WAIT;
                        dly   <= 5'(READ_DLY);
                    end
                    WAIT: begin
                        state <= (dly <= 5'd1) ? READ : WAIT;
                        dly   <= dly - 1'b1;
                    end
                    READ: if (hdr_known && issued + (LEN_W + 1)'(read_enb) >= total) state <= DRAIN;
                    default: ;
                endcase
            end
        end
    end

`ifdef ROUTER_RX_STATS_EN
    logic pkt_err;
    assign pkt_err = mismatch || addr != MY_ADDR;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else if (done) begin
            if (!pkt_err && pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 1'b1;
            if (pkt_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_router_out_reader.sv
// tb_router_out_reader: two readers (port 0 / no delay, port 1 / 28-cycle delay) fed by queue FIFO models
module tb_router_out_reader;
    typedef struct {
        logic [7:0] b;
        bit sop, eop, perr, aerr;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic vld_out[2];
    logic [7:0] data_out[2];
    logic soft_reset[2];
    logic [1:0] read_enb, rx_valid, rx_sop, rx_eop, pkt_done, parity_err, addr_err, abort, busy;
    logic [7:0] rx_data[2];
`ifdef ROUTER_RX_STATS_EN
    logic [15:0] pkt_cnt[2], err_cnt[2];
`endif

    logic [7:0] fifo[2][$];
    exp_t exp_q[2][$];
    int checks = 0, failures = 0, mp = 0;
    int lat[2], pops[2], stall_at[2], sr_at[2], stall_cnt[2], n_good[2], n_err[2];
    bit lat_on[2], sr_req[2], rd[2], flush[2], exp_abort[2];
    logic [7:0] pend[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        router_out_reader #(.DATA_W(8), .PORT_ID(g), .READ_DLY(g ? 28 : 0)) u_dut (
            .clock     (clk),
            .resetn    (resetn),
            .vld_out   (vld_out[g]),
            .data_out  (data_out[g]),
            .soft_reset(soft_reset[g]),
            .read_enb  (read_enb[g]),
            .rx_data   (rx_data[g]),
            .rx_valid  (rx_valid[g]),
            .rx_sop    (rx_sop[g]),
            .rx_eop    (rx_eop[g]),
            .pkt_done  (pkt_done[g]),
            .parity_err(parity_err[g]),
            .addr_err  (addr_err[g]),
            .abort     (abort[g]),
            .busy      (busy[g])
`ifdef ROUTER_RX_STATS_EN
            ,
            .pkt_cnt   (pkt_cnt[g]),
            .err_cnt   (err_cnt[g])
`endif
        );
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s port%0d got=%0h exp=%0h", tag, mp, got, want);
        end
    endtask

    // Packet = header {len, addr}, len payload bytes, parity = XOR of all previous bytes (optionally corrupted).
    task automatic push(int p, int len, logic [1:0] addr, bit flip);
        logic [7:0] h, b, par;
        exp_t e;
        if (exp_q[p].size() == 0 && fifo[p].size() == 0 && stall_cnt[p] == 0) begin
            lat_on[p] = 1;
            lat[p] = 0;
        end
        h = {6'(len), addr};
        par = h;
        fifo[p].push_back(h);
        e = '{h, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_q[p].push_back(e);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            par ^= b;
            fifo[p].push_back(b);
            e = '{b, 1'b0, 1'b0, 1'b0, 1'b0};
            exp_q[p].push_back(e);
        end
        if (flip) par ^= 8'(1 << $urandom_range(7));
        fifo[p].push_back(par);
        e = '{par, 1'b0, 1'b1, flip, addr != 2'(p)};
        exp_q[p].push_back(e);
        if (stall_cnt[p] == 0) vld_out[p] = 1'b1;
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            mp = p;
            flush[p] = 0;
            if (lat_on[p]) begin
                if (read_enb[p]) begin
                    chk("first_rd_latency", lat[p], p ? 29 : 1);
                    lat_on[p] = 0;
                end else if (++lat[p] > 40) begin
                    chk("first_rd_timeout", lat[p], p ? 29 : 1);
                    lat_on[p] = 0;
                end
            end
            if (abort[p] || exp_abort[p]) chk("abort", abort[p], exp_abort[p]);
            exp_abort[p] = soft_reset[p] && exp_q[p].size() > 0;
            if (exp_abort[p]) chk("rd_during_sr", read_enb[p], 0);
            rd[p] = read_enb[p];
            if (rd[p]) begin
                chk("rd_while_empty", vld_out[p], 1);
                pend[p] = fifo[p].size() > 0 ? fifo[p].pop_front() : 8'hEE;
                pops[p]++;
                if (pops[p] == stall_at[p]) begin stall_cnt[p] = 3; stall_at[p] = 0; end
                if (pops[p] == sr_at[p]) begin sr_req[p] = 1; sr_at[p] = 0; end
            end
            if (rx_valid[p]) begin
                if (exp_q[p].size() == 0) chk("rx_unexpected", 1, 0);
                else begin
                    e = exp_q[p].pop_front();
                    chk("rx_data", rx_data[p], e.b);
                    chk("rx_sop", rx_sop[p], e.sop);
                    chk("rx_eop", rx_eop[p], e.eop);
                    chk("pkt_done", pkt_done[p], e.eop);
                    if (e.eop) begin
                        chk("parity_err", parity_err[p], e.perr);
                        chk("addr_err", addr_err[p], e.aerr);
                        if (e.perr || e.aerr) n_err[p]++; else n_good[p]++;
                    end
                end
            end else if (pkt_done[p] || rx_sop[p] || rx_eop[p])
                chk("flags_without_valid", {pkt_done[p], rx_sop[p], rx_eop[p]}, 0);
            if (exp_abort[p]) begin
                exp_q[p].delete();
                flush[p] = 1;
            end
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            data_out[p] = rd[p] ? pend[p] : 8'($urandom);
            if (flush[p]) fifo[p].delete();
            soft_reset[p] = sr_req[p];
            sr_req[p] = 0;
            vld_out[p] = fifo[p].size() > 0 && stall_cnt[p] == 0;
            if (stall_cnt[p] > 0) stall_cnt[p]--;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + fifo[0].size() + fifo[1].size()) > 0 && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) begin
            chk("drain_timeout", n, 0);
            for (int p = 0; p < 2; p++) begin exp_q[p].delete(); fifo[p].delete(); end
        end
        repeat (2) step();
        for (int p = 0; p < 2; p++) begin
            mp = p;
            chk("busy_after_pkt", busy[p], 0);
            pops[p] = 0;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            mp = p;
            chk("reset_outputs", {read_enb[p], rx_data[p], rx_valid[p], rx_sop[p], rx_eop[p], pkt_done[p],
                                  parity_err[p], addr_err[p], abort[p], busy[p]}, 0);
`ifdef ROUTER_RX_STATS_EN
            chk("reset_counters", {pkt_cnt[p], err_cnt[p]}, 0);
`endif
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int p = 0; p < 2; p++) begin
            fifo[p].delete();
            exp_q[p].delete();
            vld_out[p] = 1'b0;
            soft_reset[p] = 1'b0;
            {lat_on[p], sr_req[p], rd[p], flush[p], exp_abort[p]} = '0;
            {pops[p], stall_at[p], sr_at[p], stall_cnt[p], n_good[p], n_err[p]} = '0;
        end
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            vld_out[p] = 1'b0;
            soft_reset[p] = 1'b0;
            data_out[p] = 8'h00;
        end
        do_reset();
        // clean packet, then corrupted parity
        for (int p = 0; p < 2; p++) push(p, 4, 2'd0, 0);
        drain();
        for (int p = 0; p < 2; p++) push(p, 4, 2'd0, 1);
        drain();
        // FIFO goes empty for 3 cycles after payload byte 2 is read
        for (int p = 0; p < 2; p++) begin stall_at[p] = 3; push(p, 8, 2'(p), 0); end
        drain();
        // soft reset after payload byte 3 is read, then a short packet
        for (int p = 0; p < 2; p++) begin sr_at[p] = 4; push(p, 10, 2'(p), 0); end
        drain();
        for (int p = 0; p < 2; p++) push(p, 2, 2'(p), 0);
        drain();
        // wrong address followed back-to-back by a good packet
        for (int p = 0; p < 2; p++) begin push(p, 3, 2'd2, 0); push(p, 0, 2'(p), 0); end
        drain();
        for (int it = 0; it < 16; it++) begin
            for (int p = 0; p < 2; p++) begin
                int len = $urandom_range(15);
                stall_at[p] = ($urandom_range(2) == 0) ? $urandom_range(len + 1, 1) : 0;
                push(p, len, 2'($urandom_range(3)), $urandom_range(3) == 0);
                if ($urandom_range(1) == 1) push(p, $urandom_range(6), 2'($urandom_range(3)), $urandom_range(3) == 0);
            end
            drain();
        end
`ifdef ROUTER_RX_STATS_EN
        for (int p = 0; p < 2; p++) begin
            mp = p;
            chk("pkt_cnt", pkt_cnt[p], n_good[p]);
            chk("err_cnt", err_cnt[p], n_err[p]);
        end
`endif
        // reset mid-packet must return both readers to idle even with data pending
        for (int p = 0; p < 2; p++) push(p, 6, 2'(p), 0);
        repeat (4) step();
        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
